// File: rtl/sram_frame_writer_pkg.sv
// Shared types and constants for the SRAM frame writer: FSM encoding, frame size,
// pixel struct and the R+2G+B grayscale weights.
package sram_frame_writer_pkg;

  localparam int FRAME_WORDS_DEF = 153600;
  localparam int ADDR_W_DEF      = 18;

  localparam int RGB_W  = 12;
  localparam int GRAY_W = 8;
  localparam int SUM_W  = 14;
  localparam int WORD_W = 2 * GRAY_W;

  // Weights expressed as left shifts: gray = (R + 2G + B) >> 6
  localparam int GRAY_RED_SHL   = 0;
  localparam int GRAY_GREEN_SHL = 1;
  localparam int GRAY_BLUE_SHL  = 0;
  localparam int GRAY_SHIFT     = 6;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SYNC,
    CAPTURE,
    FLUSH,
    DONE
  } frameState_t;

  typedef struct packed {
    logic [RGB_W-1:0] red;
    logic [RGB_W-1:0] green;
    logic [RGB_W-1:0] blue;
  } rgbPix_t;

  // Worst case 4095 + 8190 + 4095 = 16380, so the 14-bit sum never overflows.
  function automatic logic [GRAY_W-1:0] grayOf(input rgbPix_t pix);
    logic [SUM_W-1:0] sum;
    sum = (SUM_W'(pix.red)   << GRAY_RED_SHL)
        + (SUM_W'(pix.green) << GRAY_GREEN_SHL)
        + (SUM_W'(pix.blue)  << GRAY_BLUE_SHL);
    return sum[GRAY_SHIFT +: GRAY_W];
  endfunction

endpackage

// File: rtl/sram_frame_writer_if.sv
// Write bus between the frame writer (master) and the SRAM save stage (slave).
// The save stage registers controlState; address/data hold for two cycles per write.
interface sram_frame_writer_if
  import sram_frame_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              controlState;
  logic [ADDR_W-1:0] memoryAddress;
  logic [WORD_W-1:0] memoryData;

  modport master (
    output controlState,
    output memoryAddress,
    output memoryData
  );

  modport slave (
    input controlState,
    input memoryAddress,
    input memoryData
  );

endinterface

// File: rtl/sram_frame_writer_rgb_to_gray.sv
// Registered 12-bit RGB to 8-bit grayscale (R+2G+B)>>6; one cycle latency,
// no backpressure (valid simply follows the input valid by one cycle).
module rgb_to_gray
  import sram_frame_writer_pkg::*;
(
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              pixVld,
  input  rgbPix_t           pix,
  output logic              grayVld,
  output logic [GRAY_W-1:0] gray
);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      grayVld <= 1'b0;
      gray    <= '0;
    end else begin
      grayVld <= pixVld;
      if (pixVld) begin
        gray <= grayOf(pix);
      end
    end
  end

endmodule

// File: rtl/sram_frame_writer.sv
// Captures one armed frame, converts to gray, packs two pixels per word and writes linearly from 0.
// Write pulse lands 2 cycles after the odd pixel; no backpressure, at most one write per 2 cycles.
module sram_frame_writer
  import sram_frame_writer_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
)(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [RGB_W-1:0] iRed,
  input  logic [RGB_W-1:0] iGreen,
  input  logic [RGB_W-1:0] iBlue,
  sram_frame_writer_if.master memBus,
  output logic             oBusy,
  output logic             oDone,
  output logic             oOverflow
);

  localparam logic [ADDR_W:0] FRAME_LIMIT = (ADDR_W+1)'(FRAME_WORDS);

  frameState_t state;
  frameState_t stateNext;

  logic              fvalPrev;
  logic              fvalRise;
  logic              fvalFall;

  logic              startAccept;
  logic              pixAccept;
  logic              flushIssue;
  logic              wordIssue;

  rgbPix_t           pix;
  logic              grayVld;
  logic [GRAY_W-1:0] gray;

  logic              pending;
  logic [GRAY_W-1:0] lowByte;

  logic              ctrlQ;
  logic              holdQ;
  logic [ADDR_W-1:0] addrQ;
  logic [WORD_W-1:0] dataQ;
  logic              overflowQ;

  logic [ADDR_W:0]   nextFree;
  logic              full;

  assign fvalRise = iFVAL & ~fvalPrev;
  assign fvalFall = ~iFVAL & fvalPrev;

  assign pix = '{red: iRed, green: iGreen, blue: iBlue};

  rgb_to_gray uGray (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .pixVld  (pixAccept),
    .pix     (pix),
    .grayVld (grayVld),
    .gray    (gray)
  );

  // A word already pulsed or holding still owns addrQ, so the next free slot is one past it.
  assign nextFree  = {1'b0, addrQ} + (ADDR_W+1)'(ctrlQ | holdQ);
  assign full      = (nextFree >= FRAME_LIMIT);
  assign wordIssue = (grayVld & pending & ~full) | flushIssue;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      fvalPrev <= 1'b0;
    end else begin
      state    <= stateNext;
      fvalPrev <= iFVAL;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iStart)   stateNext = ARM;
      ARM:     if (!iFVAL)   stateNext = SYNC;
      SYNC:    if (fvalRise) stateNext = CAPTURE;
      CAPTURE: if (fvalFall) stateNext = FLUSH;
      // Leave only once the last pixel has cleared the converter and every write has finished holding.
      FLUSH:   if (!grayVld && !pending && !ctrlQ && !holdQ) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    oBusy       = 1'b0;
    oDone       = 1'b0;
    startAccept = 1'b0;
    pixAccept   = 1'b0;
    flushIssue  = 1'b0;
    unique case (state)
      IDLE:    startAccept = iStart;
      ARM:     oBusy = 1'b1;
      SYNC: begin
        oBusy     = 1'b1;
        pixAccept = iDVAL & iFVAL & fvalRise;
      end
      CAPTURE: begin
        oBusy     = 1'b1;
        pixAccept = iDVAL & iFVAL;
      end
      FLUSH: begin
        oBusy      = 1'b1;
        flushIssue = ~grayVld & pending & ~ctrlQ;
      end
      DONE:    oDone = 1'b1;
      default: ;
    endcase
  end

  // ---------------- packer, write pulse and address counter ----------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pending   <= 1'b0;
      lowByte   <= '0;
      ctrlQ     <= 1'b0;
      holdQ     <= 1'b0;
      addrQ     <= '0;
      dataQ     <= '0;
      overflowQ <= 1'b0;
    end else begin
      ctrlQ <= wordIssue;
      holdQ <= ctrlQ;

      if (wordIssue) begin
        dataQ <= grayVld ? {gray, lowByte} : {GRAY_W'(0), lowByte};
      end

      if (startAccept) begin
        addrQ <= '0;
      end else if (holdQ) begin
        addrQ <= addrQ + ADDR_W'(1);
      end

      if (startAccept) begin
        pending <= 1'b0;
      end else if (grayVld) begin
        pending <= full ? 1'b0 : ~pending;
      end else if (flushIssue) begin
        pending <= 1'b0;
      end

      if (grayVld && !full && !pending) begin
        lowByte <= gray;
      end

      if (startAccept) begin
        overflowQ <= 1'b0;
      end else if (grayVld && full) begin
        overflowQ <= 1'b1;
      end
    end
  end

  assign memBus.controlState  = ctrlQ;
  assign memBus.memoryAddress = addrQ;
  assign memBus.memoryData    = dataQ;
  assign oOverflow            = overflowQ;

endmodule
